// File: rtl/qam_symbol_mapper.sv
// -----------------------------------------------------------------------------
// qam_symbol_mapper
//
// Packs a serial bitstream into QPSK (2 bits) or 16QAM (4 bits) symbols and
// emits signed I/Q amplitude levels with a one-cycle symbol strobe. Everything
// runs on clk_in; bit pacing and symbol alignment arrive as single-cycle
// enable strobes, not as derived clocks.
//
// Optional feature macro: GRAY_MAP_EN
//   defined   : 16QAM pairs use the Gray map   00->-3U 01->-1U 11->+1U 10->+3U
//   undefined : 16QAM pairs use natural binary 00->-3U 01->-1U 10->+1U 11->+3U
//   QPSK mapping is the same in both builds.
//
// Parameters:
//   IQ_W      width of the signed I/Q outputs (two's complement)
//   QPSK_AMP  QPSK level magnitude, output is +/-QPSK_AMP
//   QAM_UNIT  16QAM unit step U, levels are +/-U and +/-3U
//
// Ports:
//   clk_in     in   1     system clock
//   rst        in   1     asynchronous reset, active-high
//   mod_type   in   1     0 = QPSK, 1 = 16QAM (latched on the first bit of a symbol)
//   bit_in     in   1     serial data bit, qualified by bit_valid
//   bit_valid  in   1     one-cycle strobe per bit, back-to-back allowed
//   sym_align  in   1     one-cycle strobe, drops any partial symbol
//   sym_i      out  IQ_W  signed in-phase level, held between symbols
//   sym_q      out  IQ_W  signed quadrature level, held between symbols
//   sym_bits   out  4     raw bits of the last symbol (QPSK uses [1:0])
//   sym_valid  out  1     one-cycle pulse when sym_i/sym_q/sym_bits update
//   busy       out  1     high while a partial symbol is held
//
// Handshake: bit_valid is a push-only strobe (no ready); each cycle with
// bit_valid high delivers exactly one bit. sym_valid is likewise a push-only
// strobe with no back-pressure; the sink must accept it in the cycle it is
// high, and the data outputs stay stable until the next strobe.
// -----------------------------------------------------------------------------
module qam_symbol_mapper #(
    parameter int IQ_W     = 8,
    parameter int QPSK_AMP = 91,
    parameter int QAM_UNIT = 32
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   mod_type,
    input  logic                   bit_in,
    input  logic                   bit_valid,
    input  logic                   sym_align,
    output logic signed [IQ_W-1:0] sym_i,
    output logic signed [IQ_W-1:0] sym_q,
    output logic [3:0]             sym_bits,
    output logic                   sym_valid,
    output logic                   busy
);

    // Amplitude levels, fixed at elaboration. Values are truncated to IQ_W;
    // choosing parameters that fit is the integrator's responsibility.
    localparam logic signed [IQ_W-1:0] QPSK_POS = IQ_W'(QPSK_AMP);
    localparam logic signed [IQ_W-1:0] QPSK_NEG = IQ_W'(-QPSK_AMP);
    localparam logic signed [IQ_W-1:0] QAM_P1   = IQ_W'(QAM_UNIT);
    localparam logic signed [IQ_W-1:0] QAM_M1   = IQ_W'(-QAM_UNIT);
    localparam logic signed [IQ_W-1:0] QAM_P3   = IQ_W'(3 * QAM_UNIT);
    localparam logic signed [IQ_W-1:0] QAM_M3   = IQ_W'(-3 * QAM_UNIT);

    localparam logic MODE_QPSK = 1'b0;
    localparam logic MODE_QAM  = 1'b1;

    // -------------------------------------------------------------------------
    // Level mapping helpers
    // -------------------------------------------------------------------------
    function automatic logic signed [IQ_W-1:0] qpsk_level(input logic b);
        return b ? QPSK_POS : QPSK_NEG;
    endfunction

    function automatic logic signed [IQ_W-1:0] qam_level(input logic [1:0] b);
        logic signed [IQ_W-1:0] lvl;
        lvl = QAM_M3;
`ifdef GRAY_MAP_EN
        case (b)
            2'b00:   lvl = QAM_M3;
            2'b01:   lvl = QAM_M1;
            2'b11:   lvl = QAM_P1;
            default: lvl = QAM_P3;   // 2'b10
        endcase
`else
        case (b)
            2'b00:   lvl = QAM_M3;
            2'b01:   lvl = QAM_M1;
            2'b10:   lvl = QAM_P1;
            default: lvl = QAM_P3;   // 2'b11
        endcase
`endif
        return lvl;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic       mode_q;     // modulation latched for the symbol in progress
    logic [1:0] cnt_q;      // bits already held for the current symbol
    logic [3:0] shreg_q;    // partial symbol, first bit ends up as MSB

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic                   mode_d;
    logic [1:0]             cnt_d;
    logic [3:0]             shreg_d;
    logic signed [IQ_W-1:0] sym_i_d;
    logic signed [IQ_W-1:0] sym_q_d;
    logic [3:0]             sym_bits_d;
    logic                   sym_done;

    // Align is applied before the incoming bit, so a bit arriving together
    // with sym_align is bit 0 of a fresh symbol.
    logic [1:0] cnt_base;
    logic [3:0] shreg_base;
    logic       mode_eff;
    logic [3:0] shifted;
    logic       last_bit;

    always_comb begin
        cnt_base   = sym_align ? 2'd0 : cnt_q;
        shreg_base = sym_align ? 4'd0 : shreg_q;

        // mod_type is only sampled on the first bit of a symbol; later
        // changes wait for the next symbol.
        mode_eff   = (cnt_base == 2'd0) ? mod_type : mode_q;
        shifted    = {shreg_base[2:0], bit_in};
        last_bit   = (mode_eff == MODE_QAM) ? (cnt_base == 2'd3)
                                            : (cnt_base == 2'd1);

        // Defaults: hold everything, only apply the align clear.
        mode_d     = mode_q;
        cnt_d      = cnt_base;
        shreg_d    = shreg_base;
        sym_i_d    = sym_i;
        sym_q_d    = sym_q;
        sym_bits_d = sym_bits;
        sym_done   = 1'b0;

        if (bit_valid) begin
            mode_d = mode_eff;
            if (last_bit) begin
                sym_done = 1'b1;
                cnt_d    = 2'd0;
                shreg_d  = 4'd0;
                if (mode_eff == MODE_QAM) begin
                    sym_i_d    = qam_level(shifted[3:2]);
                    sym_q_d    = qam_level(shifted[1:0]);
                    sym_bits_d = shifted;
                end else begin
                    sym_i_d    = qpsk_level(shifted[1]);
                    sym_q_d    = qpsk_level(shifted[0]);
                    sym_bits_d = {2'b00, shifted[1:0]};
                end
            end else begin
                cnt_d   = 2'(cnt_base + 2'd1);
                shreg_d = shifted;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            mode_q    <= MODE_QPSK;
            cnt_q     <= 2'd0;
            shreg_q   <= 4'd0;
            sym_i     <= '0;
            sym_q     <= '0;
            sym_bits  <= 4'd0;
            sym_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            sym_i     <= sym_i_d;
            sym_q     <= sym_q_d;
            sym_bits  <= sym_bits_d;
            sym_valid <= sym_done;
            busy      <= (cnt_d != 2'd0);
        end
    end

endmodule

// File: tb/tb_qam_symbol_mapper.sv
// -----------------------------------------------------------------------------
// tb_qam_symbol_mapper
//
// Directed bench for qam_symbol_mapper with default parameters
// (IQ_W = 8, QPSK_AMP = 91, QAM_UNIT = 32). Expected symbols are pushed into
// exp_q as {sym_i, sym_q, sym_bits}; a monitor pops and compares on every
// sym_valid. Inputs change 1 ns after the rising edge, the monitor samples on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_qam_symbol_mapper;

    localparam int W = 20;  // 8 + 8 + 4

    // Hand-computed levels (8-bit two's complement)
    localparam logic [7:0] P91 = 8'h5B;   // +91
    localparam logic [7:0] M91 = 8'hA5;   // -91
    localparam logic [7:0] P32 = 8'h20;   // +32
    localparam logic [7:0] M32 = 8'hE0;   // -32
    localparam logic [7:0] P96 = 8'h60;   // +96
    localparam logic [7:0] M96 = 8'hA0;   // -96

    logic              clk_in;
    logic              rst;
    logic              mod_type;
    logic              bit_in;
    logic              bit_valid;
    logic              sym_align;
    logic signed [7:0] sym_i;
    logic signed [7:0] sym_q;
    logic [3:0]        sym_bits;
    logic              sym_valid;
    logic              busy;

    logic [W-1:0] exp_q[$];
    int           valid_cycles[$];
    int           checks;
    int           errors;
    int           cyc;

    qam_symbol_mapper dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .mod_type  (mod_type),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .sym_align (sym_align),
        .sym_i     (sym_i),
        .sym_q     (sym_q),
        .sym_bits  (sym_bits),
        .sym_valid (sym_valid),
        .busy      (busy)
    );

    // ---------------------------------------------------------------- clock
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(posedge clk_in) cyc <= cyc + 1;

    // ----------------------------------------------------------- monitor/sb
    always @(negedge clk_in) begin
        if (!rst && sym_valid) begin
            logic [W-1:0] exp_v;
            valid_cycles.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sym actual i=%0h q=%0h bits=%b required none",
                         sym_i, sym_q, sym_bits);
            end else begin
                exp_v = exp_q.pop_front();
                if ({sym_i, sym_q, sym_bits} !== exp_v) begin
                    errors++;
                    $display("FAIL sym_out actual i=%0h q=%0h bits=%b required i=%0h q=%0h bits=%b",
                             sym_i, sym_q, sym_bits, exp_v[19:12], exp_v[11:4], exp_v[3:0]);
                end
            end
        end
    end

    // --------------------------------------------------------------- tasks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input logic bv, input logic b, input logic mt, input logic al);
        @(posedge clk_in);
        #1;
        bit_valid = bv;
        bit_in    = b;
        mod_type  = mt;
        sym_align = al;
    endtask

    task automatic push_exp(input logic [7:0] i, input logic [7:0] q, input logic [3:0] bits);
        exp_q.push_back({i, q, bits});
    endtask

    // Idle until the scoreboard drains (bounded), plus a few extra cycles so
    // stray pulses land in the monitor.
    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        check({"drain_", name}, exp_q.size(), 0);
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        rst       = 1'b1;
        mod_type  = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        sym_align = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 rst = 1'b0;

        // Reset state
        check("rst_sym_i",     sym_i,     0);
        check("rst_sym_q",     sym_q,     0);
        check("rst_sym_bits",  sym_bits,  0);
        check("rst_sym_valid", sym_valid, 0);
        check("rst_busy",      busy,      0);

        // QPSK 1,0 -> +91 / -91
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        push_exp(P91, M91, 4'b0010);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("qpsk_busy_mid", busy, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("qpsk_busy_done", busy, 0);
        drain("qpsk_basic");

        // 16QAM 1,0,0,1
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
`ifdef GRAY_MAP_EN
        push_exp(P96, M32, 4'b1001);
`else
        push_exp(P32, M32, 4'b1001);
`endif
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drain("qam_basic");

        // 16QAM partial (1,1), align alone, then 0,1,1,1
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        check("align_busy_before", busy, 1);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        check("align_busy_after", busy, 0);
`ifdef GRAY_MAP_EN
        check("align_hold_i", sym_i, P96);
`else
        check("align_hold_i", sym_i, P32);
`endif
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
`ifdef GRAY_MAP_EN
        push_exp(M32, P32, 4'b0111);
`else
        push_exp(M32, P96, 4'b0111);
`endif
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drain("qam_align");

        // Align together with a bit: 16QAM 1,0 dropped, new QPSK symbol 1,1
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        push_exp(P91, P91, 4'b0011);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drain("align_with_bit");

        // mod_type drops to QPSK after the first bit of a 16QAM symbol
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
`ifdef GRAY_MAP_EN
        push_exp(P32, M96, 4'b1100);
`else
        push_exp(P96, M96, 4'b1100);
`endif
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        push_exp(M91, P91, 4'b0001);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drain("mode_change");

        // QPSK back-to-back: 8 bits -> 4 symbols two cycles apart
        valid_cycles.delete();
        push_exp(P91, P91, 4'b0011);
        push_exp(M91, M91, 4'b0000);
        push_exp(P91, M91, 4'b0010);
        push_exp(M91, P91, 4'b0001);
        begin
            logic [7:0] pat;
            pat = 8'b1100_1001;
            for (int k = 7; k >= 0; k--) drive(1'b1, pat[k], 1'b0, 1'b0);
        end
        drain("qpsk_b2b");
        check("b2b_count", valid_cycles.size(), 4);
        if (valid_cycles.size() == 4) begin
            for (int k = 1; k < 4; k++)
                check("b2b_spacing", valid_cycles[k] - valid_cycles[k-1], 2);
        end

        // Reset mid-symbol after 3 of 4 bits
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_sym_i",    sym_i,    0);
        check("mid_rst_sym_q",    sym_q,    0);
        check("mid_rst_sym_bits", sym_bits, 0);
        check("mid_rst_busy",     busy,     0);
        @(posedge clk_in);
        #1 rst = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
`ifdef GRAY_MAP_EN
        push_exp(M96, P96, 4'b0010);
`else
        push_exp(M96, P32, 4'b0010);
`endif
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drain("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
